decode_stage_pipe: RTL and testbench

Registered, flow-controlled instruction decode stage for the pipelined core. It generalises the combinational main decoder. Each instruction is decoded into the same control bundle, which is then held in a 2-entry output buffer with valid/ready handshakes on both sides and a synchronous flush. It also carries an optional illegal-opcode detector with a saturating event counter. It sits between the IF/ID register and the execute stage.

---
 rtl/decode_pkg.sv | 77 +++++++
 rtl/ctrl_skid_buffer.sv | 83 ++++++++
 rtl/decode_stage_pipe.sv | 94 +++++++++
 tb/tb_decode_stage_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode stage: control bundle, opcodes,
// immediate/result selects and the output-buffer state.
package decode_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       pc_op;
    logic       mem_read;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_AUIPC = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_e;

  function automatic ctrl_t mk_ctrl(
    input logic       rw,
    input logic [2:0] imm,
    input logic       alu_src,
    input logic       mem_write,
    input logic [1:0] res,
    input logic       branch,
    input logic [1:0] alu_op,
    input logic       pc_op,
    input logic       mem_read
  );
    ctrl_t c;
    c.reg_write  = rw;
    c.imm_src    = imm;
    c.alu_src    = alu_src;
    c.mem_write  = mem_write;
    c.result_src = res;
    c.branch     = branch;
    c.alu_op     = alu_op;
    c.pc_op      = pc_op;
    c.mem_read   = mem_read;
    return c;
  endfunction

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_STORE, OP_REG, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_skid_buffer.sv
// Generic 2-entry valid/ready buffer: primary register drives the outputs,
// skid register absorbs one extra word; in_ready is registered.
module ctrl_skid_buffer
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] prim_q, prim_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, handoff;

  assign accept  = in_valid && in_ready_q;
  assign handoff = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    prim_d  = prim_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          prim_d  = in_data;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (accept && handoff) begin
            prim_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (handoff) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (handoff) begin
          prim_d  = skid_q;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Flags follow the next state so both leave the flop already settled.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      prim_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      prim_q      <= prim_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = prim_q;

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered, flow-controlled decode stage: opcode decode into ctrl_t feeding a
// 2-entry skid buffer. Optional illegal-opcode trap via DECODE_ILLEGAL_TRAP_EN.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output ctrl_t                out_ctrl,
  output logic [31:0]          out_instr,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam int unsigned PW = $bits(ctrl_t) + 32 + PC_WIDTH + 1;

  logic [6:0]    opcode;
  ctrl_t         dec_ctrl;
  logic          dec_illegal;
  logic [PW-1:0] buf_in, buf_out;

  assign opcode = in_instr[6:0];

  always_comb begin
    dec_ctrl = '0;
    case (opcode)
      OP_LOAD:   dec_ctrl = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_MEM,   1'b0, 2'b00, 1'b0, 1'b1);
      OP_IMM:    dec_ctrl = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_ALU,   1'b0, 2'b10, 1'b0, 1'b0);
      OP_STORE:  dec_ctrl = mk_ctrl(1'b0, IMM_S, 1'b1, 1'b1, RES_ALU,   1'b0, 2'b00, 1'b0, 1'b0);
      OP_REG:    dec_ctrl = mk_ctrl(1'b1, IMM_R, 1'b0, 1'b0, RES_ALU,   1'b0, 2'b10, 1'b0, 1'b0);
      OP_BRANCH: dec_ctrl = mk_ctrl(1'b0, IMM_B, 1'b0, 1'b0, RES_ALU,   1'b1, 2'b01, 1'b0, 1'b0);
      OP_LUI:    dec_ctrl = mk_ctrl(1'b1, IMM_U, 1'b1, 1'b0, RES_ALU,   1'b0, 2'b00, 1'b0, 1'b0);
      OP_AUIPC:  dec_ctrl = mk_ctrl(1'b1, IMM_U, 1'b1, 1'b0, RES_AUIPC, 1'b0, 2'b00, 1'b0, 1'b0);
      OP_JAL:    dec_ctrl = mk_ctrl(1'b1, IMM_J, 1'b1, 1'b0, RES_PC4,   1'b1, 2'b00, 1'b0, 1'b0);
      OP_JALR:   dec_ctrl = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_PC4,   1'b1, 2'b10, 1'b1, 1'b0);
      default:   dec_ctrl = '0;
    endcase
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign dec_illegal = !is_known_op(opcode);
`else
  assign dec_illegal = 1'b0;
`endif

  assign buf_in = {dec_ctrl, in_instr, in_pc, dec_illegal};

  ctrl_skid_buffer #(
    .WIDTH (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign {out_ctrl, out_instr, out_pc, out_illegal} = buf_out;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A handoff coinciding with flush is discarded, so it is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && out_illegal && !flush && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign illegal_count = cnt_q;
`else
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scoreboard bench for decode_stage_pipe; a CNT_WIDTH=2 instance runs
// in lockstep on the same stimulus to observe counter saturation.
module tb_decode_stage_pipe;
  import decode_pkg::*;

  localparam int unsigned PCW = 32;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0]    in_instr, out_instr;
  logic [PCW-1:0] in_pc, out_pc;
  ctrl_t          out_ctrl;
  logic [15:0]    illegal_count;

  logic           sat_in_ready, sat_out_valid, sat_illegal;
  ctrl_t          sat_ctrl;
  logic [31:0]    sat_instr;
  logic [PCW-1:0] sat_pc;
  logic [1:0]     sat_count;

  always #5 clk = ~clk;

  decode_stage_pipe #(.PC_WIDTH(PCW), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_instr(out_instr),
    .out_pc(out_pc), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  decode_stage_pipe #(.PC_WIDTH(PCW), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_ctrl(sat_ctrl), .out_instr(sat_instr),
    .out_pc(sat_pc), .out_illegal(sat_illegal), .illegal_count(sat_count)
  );

  typedef struct {
    logic [12:0]    ctrl;
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic           ill;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_cnt = '0;
  logic [1:0]  exp_sat = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [PCW-1:0] pc);
    exp_t e;
    e.instr = ins;
    e.pc    = pc;
    e.ill   = 1'b0;
    case (ins[6:0])
      7'b0000011: e.ctrl = 13'b1_001_1_0_01_0_00_0_1;
      7'b0010011: e.ctrl = 13'b1_001_1_0_00_0_10_0_0;
      7'b0100011: e.ctrl = 13'b0_010_1_1_00_0_00_0_0;
      7'b0110011: e.ctrl = 13'b1_000_0_0_00_0_10_0_0;
      7'b1100011: e.ctrl = 13'b0_011_0_0_00_1_01_0_0;
      7'b0110111: e.ctrl = 13'b1_100_1_0_00_0_00_0_0;
      7'b0010111: e.ctrl = 13'b1_100_1_0_11_0_00_0_0;
      7'b1101111: e.ctrl = 13'b1_101_1_0_10_1_00_0_0;
      7'b1100111: e.ctrl = 13'b1_001_1_0_10_1_10_1_0;
      default: begin
        e.ctrl = '0;
        e.ill  = TRAP;
      end
    endcase
    return e;
  endfunction

  // One clock: called at a negedge with inputs already driven.
  task automatic cycle(output bit acc);
    exp_t e;
    chk("out_valid_occ", out_valid, q.size() != 0);
    chk("in_ready_occ", in_ready, q.size() < 2);
    chk("sat_valid_occ", sat_out_valid, q.size() != 0);
    chk("sat_ready_occ", sat_in_ready, q.size() < 2);
    if (out_valid && out_ready && !flush && q.size() != 0) begin
      e = q.pop_front();
      chk("out_ctrl", out_ctrl, e.ctrl);
      chk("out_instr", out_instr, e.instr);
      chk("out_pc", out_pc, e.pc);
      chk("out_illegal", out_illegal, e.ill);
      chk("sat_ctrl", sat_ctrl, e.ctrl);
      chk("sat_pc", sat_pc, e.pc);
      chk("sat_instr", sat_instr, e.instr);
      chk("sat_illegal", sat_illegal, e.ill);
      if (e.ill) begin
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        if (exp_sat != 2'd3) exp_sat++;
      end
    end
    acc = in_valid && in_ready && !flush;
    if (flush) q.delete();
    else if (acc) q.push_back(model(in_instr, in_pc));
    @(posedge clk);
    @(negedge clk);
    chk("illegal_count", illegal_count, exp_cnt);
    chk("sat_count", sat_count, exp_sat);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) cycle(acc);
    chk("drain_budget", q.size(), 0);
    cycle(acc);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    q.delete();
    exp_cnt = '0;
    exp_sat = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          acc;
    logic [31:0] r;
    logic [6:0]  ops [9];
    ops = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_count", illegal_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All nine opcodes back-to-back at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      r = $urandom();
      in_valid = 1'b1;
      in_instr = {r[31:7], ops[i]};
      in_pc    = 32'h1000 + 32'(4 * i);
      cycle(acc);
      chk("stream_accept", acc, 1);
    end
    drain();

    // Backpressure: two accepted, third held upstream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h2000;
    cycle(acc); chk("bp_acc1", acc, 1);
    in_instr = 32'h00A0_0093; in_pc = 32'h2004;
    cycle(acc); chk("bp_acc2", acc, 1);
    in_instr = 32'h0000_0073; in_pc = 32'h2008;
    chk("bp_full_ready", in_ready, 0);
    cycle(acc); chk("bp_held", acc, 0);
    chk("bp_pc_hold", out_pc, 32'h2000);
    cycle(acc); chk("bp_held2", acc, 0);
    chk("bp_pc_hold2", out_pc, 32'h2000);
    out_ready = 1'b1;
    cycle(acc); chk("bp_no_acc_full", acc, 0);
    out_ready = 1'b0;
    chk("bp_pc_next", out_pc, 32'h2004);
    chk("bp_ready_back", in_ready, 1);
    cycle(acc); chk("bp_acc3", acc, 1);
    drain();

    // Flush in ONE together with an accept of a load.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h3000;
    cycle(acc);
    flush = 1'b1; in_instr = 32'h0000_2083; in_pc = 32'h3004;
    cycle(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drain();

    // Illegal opcodes with a fresh counter.
    sync_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'hFFFF_FFFF; in_pc = 32'h4000 + 32'(4 * i);
      cycle(acc);
    end
    drain();
    chk("illegal_count3", illegal_count, TRAP ? 16'd3 : 16'd0);
    in_valid = 1'b1; in_instr = 32'h0000_0010; in_pc = 32'h4100;
    cycle(acc);
    in_instr = 32'h1234_567F; in_pc = 32'h4104;
    cycle(acc);
    drain();
    chk("illegal_count5", illegal_count, TRAP ? 16'd5 : 16'd0);
    chk("sat_count_cap", sat_count, TRAP ? 2'd3 : 2'd0);

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0033; in_pc = 32'h5000;
    cycle(acc);
    in_instr = 32'h0000_0063; in_pc = 32'h5004;
    cycle(acc);
    chk("pre_rst_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_count", illegal_count, 0);
    q.delete();
    exp_cnt = '0;
    exp_sat = '0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
